program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 130 +++++++++++++
 tb/tb_program_loader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//
// Receives a byte stream from upstream and writes a program into instruction
// memory. The stream is a count byte N (0 means 256), then N words each sent
// as a high byte and a low byte, then one checksum byte. The checksum is the
// modulo-256 sum of the count byte and every word byte. When the load
// completes cleanly, the processor is released. Any format or checksum fault
// parks the loader in an error state until reload or reset.
//
// Ports
//   clk         single clock, all state changes on its rising edge
//   reset_n     synchronous active-low reset
//   in_valid    upstream byte valid
//   in_data     upstream byte
//   in_ready    loader can accept a byte
//   reload      one-cycle request to restart loading
//   imem_we     instruction memory write strobe (one cycle per word)
//   imem_addr   instruction memory write address (held when imem_we = 0)
//   imem_wdata  instruction word {opcode[1:0], operand[7:0]} (held likewise)
//   cpu_run     processor may execute; low holds it in reset
//   load_error  sticky format or checksum error
//   state_dbg   current FSM state, exposed for checkers
//
// Handshake: a byte moves only on a rising edge where in_valid and in_ready
// are both 1. in_data is ignored on every other edge. in_ready depends on
// state alone, so a held in_valid streams one byte per cycle.
// ---------------------------------------------------------------------------
module program_loader #(
   parameter bit CHECKSUM_EN = 1'b1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   input  logic       reload,
   output logic       imem_we,
   output logic [7:0] imem_addr,
   output logic [9:0] imem_wdata,
   output logic       cpu_run,
   output logic       load_error,
   output logic [2:0] state_dbg
);

   localparam logic [2:0] S_COUNT = 3'd0;
   localparam logic [2:0] S_HI    = 3'd1;
   localparam logic [2:0] S_LO    = 3'd2;
   localparam logic [2:0] S_CHECK = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_ERROR = 3'd5;

   logic [2:0] state;
   logic [7:0] count;      // N as received; 0 encodes 256 words
   logic [7:0] word_idx;   // index of the word currently being received
   logic [7:0] checksum;   // running modulo-256 sum
   logic [1:0] hi_bits;    // opcode bits captured from the high byte
   logic       xfer;
   logic       last_word;

   assign in_ready   = (state == S_COUNT) || (state == S_HI) ||
                       (state == S_LO)    || (state == S_CHECK);
   assign xfer       = in_valid && in_ready;
   assign cpu_run    = (state == S_DONE);
   // ERROR is left only through reload or reset, so the flag is sticky.
   assign load_error = (state == S_ERROR);
   assign state_dbg  = state;

   // With N = 0, count - 1 = 255, so the last word is word 255 and the
   // index wraps to 0 only after that final word.
   assign last_word  = (word_idx == (count - 8'd1));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= S_COUNT;
         count      <= 8'd0;
         word_idx   <= 8'd0;
         checksum   <= 8'd0;
         hi_bits    <= 2'd0;
         imem_we    <= 1'b0;
         imem_addr  <= 8'd0;
         imem_wdata <= 10'd0;
      end else begin
         // Write strobe is a single-cycle pulse; address/data hold otherwise.
         imem_we <= 1'b0;
         if (reload) begin
            // Any byte presented alongside reload is dropped.
            state    <= S_COUNT;
            checksum <= 8'd0;
            word_idx <= 8'd0;
         end else if (xfer) begin
            case (state)
               S_COUNT: begin
                  count    <= in_data;
                  checksum <= checksum + in_data;
                  state    <= S_HI;
               end
               S_HI: begin
                  if (in_data[7:2] != 6'd0) begin
                     state <= S_ERROR;
                  end else begin
                     hi_bits  <= in_data[1:0];
                     checksum <= checksum + in_data;
                     state    <= S_LO;
                  end
               end
               S_LO: begin
                  imem_we    <= 1'b1;
                  imem_addr  <= word_idx;
                  imem_wdata <= {hi_bits, in_data};
                  checksum   <= checksum + in_data;
                  word_idx   <= word_idx + 8'd1;
                  state      <= last_word ? S_CHECK : S_HI;
               end
               S_CHECK: begin
                  if (!CHECKSUM_EN || (in_data == checksum)) begin
                     state <= S_DONE;
                  end else begin
                     state <= S_ERROR;
                  end
               end
               default: begin
                  state <= state;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
//
// Drives byte streams into program_loader and compares every memory write
// and the final run/error status against a stream-level reference model.
// ---------------------------------------------------------------------------
module tb_program_loader;

   logic       clk;
   logic       reset_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       reload;
   logic       imem_we;
   logic [7:0] imem_addr;
   logic [9:0] imem_wdata;
   logic       cpu_run;
   logic       load_error;
   logic [2:0] state_dbg;

   int checks   = 0;
   int failures = 0;

   // Expected writes, each {addr[7:0], wdata[9:0]}, in order.
   logic [17:0] exp_q[$];

   program_loader #(.CHECKSUM_EN(1'b1)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .reload     (reload),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_run    (cpu_run),
      .load_error (load_error),
      .state_dbg  (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Write monitor: every strobe must match the next expected write.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         if (exp_q.size() > 0) begin
            check("imem_write", {14'd0, imem_addr, imem_wdata}, {14'd0, exp_q.pop_front()});
         end else begin
            check("unexpected_we", {31'd0, imem_we}, 32'd0);
         end
      end
   end

   // ---------------- reference model ----------------
   // Walks a byte stream by the format rules and queues the writes it
   // implies. Returns 0 = stream still in progress, 1 = load completes,
   // 2 = error. used = number of bytes the loader will accept.
   function automatic int model(input logic [7:0] s[$], output int used);
      int         words;
      int         idx;
      logic [7:0] sum;
      logic [7:0] hi;
      logic [7:0] lo;
      logic [7:0] k8;
      used = s.size();
      if (s.size() == 0) return 0;
      words = (s[0] == 8'd0) ? 256 : int'(s[0]);
      sum   = s[0];
      idx   = 1;
      for (int k = 0; k < words; k++) begin
         if (idx >= s.size()) return 0;
         hi = s[idx];
         idx++;
         if (hi > 8'd3) begin
            used = idx;
            return 2;
         end
         sum = sum + hi;
         if (idx >= s.size()) return 0;
         lo = s[idx];
         idx++;
         sum = sum + lo;
         k8 = k[7:0];
         exp_q.push_back({k8, hi[1:0], lo});
      end
      if (idx >= s.size()) return 0;
      used = idx + 1;
      return (s[idx] == sum) ? 1 : 2;
   endfunction

   // ---------------- drivers ----------------
   // Presents bytes, inserting idle cycles with probability gap_pct percent
   // (with junk on in_data). Returns on the falling edge just after the
   // final byte transferred.
   task automatic drive(input logic [7:0] d[$], input int gap_pct);
      int i = 0;
      int guard = 0;
      while (i < d.size() && guard < 5000) begin
         @(negedge clk);
         if ($urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
         end else begin
            in_valid = 1'b1;
            in_data  = d[i];
            if (in_ready) begin
               if (i == d.size() - 1) check("cpu_run_early", {31'd0, cpu_run}, 32'd0);
               i++;
            end
         end
         guard++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      check("drive_bytes", i, d.size());
   endtask

   // Model a stream, drive what the loader will accept, check status.
   task automatic run_stream(input string tag, input logic [7:0] s[$], input int gap_pct);
      int         status;
      int         used;
      logic [7:0] d[$];
      status = model(s, used);
      d = {};
      for (int i = 0; i < used; i++) d.push_back(s[i]);
      drive(d, gap_pct);
      check({tag, "_cpu_run"},    {31'd0, cpu_run},    (status == 1) ? 32'd1 : 32'd0);
      check({tag, "_load_error"}, {31'd0, load_error}, (status == 2) ? 32'd1 : 32'd0);
      check({tag, "_in_ready"},   {31'd0, in_ready},   (status == 0) ? 32'd1 : 32'd0);
   endtask

   task automatic settle(input string tag);
      repeat (2) @(negedge clk);
      check({tag, "_writes_left"}, exp_q.size(), 32'd0);
   endtask

   // One-cycle reload, with a random byte offered in the same cycle.
   task automatic pulse_reload(input string tag);
      reload   = 1'b1;
      in_valid = 1'($urandom);
      in_data  = 8'($urandom);
      @(negedge clk);
      reload   = 1'b0;
      in_valid = 1'b0;
      check({tag, "_rl_load_error"}, {31'd0, load_error}, 32'd0);
      check({tag, "_rl_cpu_run"},    {31'd0, cpu_run},    32'd0);
      check({tag, "_rl_in_ready"},   {31'd0, in_ready},   32'd1);
   endtask

   // ---------------- stimulus ----------------
   logic [7:0] s[$];
   logic [7:0] sum;
   logic [7:0] b;
   int         n;

   initial begin
      reset_n  = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'd0;
      reload   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_imem_we",    {31'd0, imem_we},    32'd0);
      check("rst_imem_addr",  {24'd0, imem_addr},  32'd0);
      check("rst_imem_wdata", {22'd0, imem_wdata}, 32'd0);
      check("rst_cpu_run",    {31'd0, cpu_run},    32'd0);
      check("rst_load_error", {31'd0, load_error}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready",   {31'd0, in_ready},   32'd1);

      // Basic two-word load, back-to-back.
      s = '{8'h02, 8'h00, 8'h05, 8'h01, 8'hFF, 8'h07};
      run_stream("basic", s, 0);
      settle("basic");

      // Same stream with a wrong checksum, then recover via reload.
      pulse_reload("bad_ck");
      s = '{8'h02, 8'h00, 8'h05, 8'h01, 8'hFF, 8'h08};
      run_stream("bad_ck", s, 0);
      settle("bad_ck");
      check("bad_ck_sticky", {31'd0, load_error}, 32'd1);
      pulse_reload("bad_ck_after");

      // Illegal high byte: error with no write; further bytes refused.
      s = '{8'h01, 8'h04, 8'h00, 8'h05};
      run_stream("bad_hi", s, 0);
      in_valid = 1'b1;
      in_data  = 8'h00;
      repeat (4) @(negedge clk);
      in_valid = 1'b0;
      check("bad_hi_in_ready", {31'd0, in_ready}, 32'd0);
      settle("bad_hi");

      // N = 0: 256 random words plus correct checksum.
      pulse_reload("n256");
      s = '{8'h00};
      sum = 8'h00;
      for (int k = 0; k < 256; k++) begin
         b = 8'($urandom_range(3));
         s.push_back(b);
         sum = sum + b;
         b = 8'($urandom);
         s.push_back(b);
         sum = sum + b;
      end
      s.push_back(sum);
      run_stream("n256", s, 0);
      settle("n256");

      // Basic stream with random valid gaps and junk data in the gaps.
      pulse_reload("gaps");
      s = '{8'h02, 8'h00, 8'h05, 8'h01, 8'hFF, 8'h07};
      run_stream("gaps", s, 40);
      settle("gaps");

      // Reload while a write is still pending: that write completes.
      pulse_reload("pend");
      s = '{8'h02, 8'h00, 8'h05};
      run_stream("pend", s, 0);
      pulse_reload("pend");
      settle("pend");

      // Reload mid-word, then a full clean load.
      s = '{8'h03, 8'h02, 8'h11, 8'h01};
      run_stream("mid", s, 20);
      pulse_reload("mid");
      s = '{8'h02, 8'h00, 8'h05, 8'h01, 8'hFF, 8'h07};
      run_stream("mid_after", s, 0);
      settle("mid_after");

      // Random legal streams, some with corrupted checksums.
      for (int t = 0; t < 4; t++) begin
         pulse_reload("rand");
         n = $urandom_range(20, 1);
         s = {};
         s.push_back(8'(n));
         sum = 8'(n);
         for (int k = 0; k < n; k++) begin
            b = 8'($urandom_range(3));
            s.push_back(b);
            sum = sum + b;
            b = 8'($urandom);
            s.push_back(b);
            sum = sum + b;
         end
         if (t == 2) sum = sum + 8'h5A;
         s.push_back(sum);
         run_stream("rand", s, 30);
         settle("rand");
      end

      // Reset in LO (with reload also high): no write, outputs to reset.
      pulse_reload("rst_lo");
      s = '{8'h02, 8'h01, 8'h33, 8'h02};
      run_stream("rst_lo", s, 0);
      settle("rst_lo_pre");
      reset_n  = 1'b0;
      reload   = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h44;
      @(negedge clk);
      check("rst_lo_imem_we",    {31'd0, imem_we},    32'd0);
      check("rst_lo_imem_addr",  {24'd0, imem_addr},  32'd0);
      check("rst_lo_imem_wdata", {22'd0, imem_wdata}, 32'd0);
      check("rst_lo_cpu_run",    {31'd0, cpu_run},    32'd0);
      check("rst_lo_load_error", {31'd0, load_error}, 32'd0);
      check("rst_lo_in_ready",   {31'd0, in_ready},   32'd1);
      reset_n  = 1'b1;
      reload   = 1'b0;
      in_valid = 1'b0;
      s = '{8'h02, 8'h00, 8'h05, 8'h01, 8'hFF, 8'h07};
      run_stream("post_rst", s, 0);
      settle("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
